// File: rtl/vit_acs_pkg.sv
// Shared trellis definitions for the (2,1,3) convolutional code: state geometry,
// generator polynomials and the branch output / Hamming metric helpers.
package vit_acs_pkg;

    localparam int unsigned N_STATES = 8;
    localparam int unsigned K        = 4;
    localparam int unsigned S_W      = K - 1;
    localparam int unsigned N_BFLY   = N_STATES / 2;
    localparam int unsigned SYM_W    = 2;
    localparam int unsigned BM_W     = 2;

    localparam logic [K-1:0] G1 = 4'b1011;
    localparam logic [K-1:0] G0 = 4'b1111;

    // Encoder output {v1,v0} when input u is shifted into a register holding state.
    function automatic logic [SYM_W-1:0] branch_out(input logic [S_W-1:0] state,
                                                     input logic           u);
        logic [K-1:0] shift_reg;
        shift_reg = {u, state};
        return {^(shift_reg & G1), ^(shift_reg & G0)};
    endfunction

    function automatic logic [BM_W-1:0] branch_metric(input logic [SYM_W-1:0] rx,
                                                       input logic [SYM_W-1:0] code);
        logic [SYM_W-1:0] diff;
        diff = rx ^ code;
        return BM_W'(diff[1]) + BM_W'(diff[0]);
    endfunction

endpackage

// File: rtl/vit_acs_butterfly.sv
// One radix-2 butterfly: predecessors {j,0}/{j,1} feed next states {0,j}/{1,j}.
// Branches into the two next states use complementary metrics, so two BMs suffice.
module vit_acs_butterfly
    import vit_acs_pkg::*;
#(
    parameter int unsigned PM_W = 6
) (
    input  logic [PM_W-1:0] pm0,
    input  logic [PM_W-1:0] pm1,
    input  logic [BM_W-1:0] bm_a,
    input  logic [BM_W-1:0] bm_b,
    output logic [PM_W-1:0] pm_lo_c,
    output logic [PM_W-1:0] pm_hi_c,
    output logic            dec_lo_c,
    output logic            dec_hi_c
);

    localparam int unsigned     SUM_W = PM_W + 1;
    localparam logic [SUM_W-1:0] SAT  = {1'b0, {PM_W{1'b1}}};

    logic [SUM_W-1:0] cand_lo0;
    logic [SUM_W-1:0] cand_lo1;
    logic [SUM_W-1:0] cand_hi0;
    logic [SUM_W-1:0] cand_hi1;
    logic [SUM_W-1:0] sel_lo;
    logic [SUM_W-1:0] sel_hi;

    // bm_a: {j,0}->{0,j} and {j,1}->{1,j}; bm_b: the two crossing branches.
    always_comb begin
        cand_lo0 = SUM_W'(pm0) + SUM_W'(bm_a);
        cand_lo1 = SUM_W'(pm1) + SUM_W'(bm_b);
        cand_hi0 = SUM_W'(pm0) + SUM_W'(bm_b);
        cand_hi1 = SUM_W'(pm1) + SUM_W'(bm_a);

        dec_lo_c = (cand_lo1 < cand_lo0);
        dec_hi_c = (cand_hi1 < cand_hi0);
        sel_lo   = dec_lo_c ? cand_lo1 : cand_lo0;
        sel_hi   = dec_hi_c ? cand_hi1 : cand_hi0;

        pm_lo_c  = (sel_lo > SAT) ? SAT[PM_W-1:0] : sel_lo[PM_W-1:0];
        pm_hi_c  = (sel_hi > SAT) ? SAT[PM_W-1:0] : sel_hi[PM_W-1:0];
    end

endmodule

// File: rtl/vit_acs.sv
// Add-compare-select stage: per valid symbol updates 8 path metrics, emits the
// survivor decisions and the best state/metric one cycle later.
module vit_acs
    import vit_acs_pkg::*;
#(
    parameter int unsigned PM_W    = 6,
    parameter int unsigned INIT_PM = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [SYM_W-1:0]      rx_sym,
    input  logic                  sym_valid,
    output logic [N_STATES-1:0]   dec,
    output logic                  dec_valid,
    output logic [S_W-1:0]        best_state,
    output logic [PM_W-1:0]       best_metric
);

    localparam logic [PM_W-1:0] INIT_VAL = PM_W'(INIT_PM);

    logic [N_STATES-1:0][PM_W-1:0] pm_q;
    logic [N_STATES-1:0][PM_W-1:0] pm_new;
    logic [N_STATES-1:0][PM_W-1:0] pm_upd;
    logic [N_STATES-1:0]           dec_new;
    logic [N_BFLY-1:0][BM_W-1:0]   bm_a;
    logic [N_BFLY-1:0][BM_W-1:0]   bm_b;
    logic                          norm_c;
    logic [S_W-1:0]                min_idx;
    logic [PM_W-1:0]               min_val;

    // Branch metrics of the u=0 transitions out of {j,0} and {j,1}.
    always_comb begin
        bm_a = '0;
        bm_b = '0;
        for (int j = 0; j < int'(N_BFLY); j++) begin
            bm_a[j] = branch_metric(rx_sym, branch_out(S_W'(2 * j), 1'b0));
            bm_b[j] = branch_metric(rx_sym, branch_out(S_W'(2 * j + 1), 1'b0));
        end
    end

    for (genvar j = 0; j < int'(N_BFLY); j++) begin : g_bfly
        vit_acs_butterfly #(
            .PM_W     (PM_W)
        ) u_bfly (
            .pm0      (pm_q[2*j]),
            .pm1      (pm_q[2*j+1]),
            .bm_a     (bm_a[j]),
            .bm_b     (bm_b[j]),
            .pm_lo_c  (pm_new[j]),
            .pm_hi_c  (pm_new[j+N_BFLY]),
            .dec_lo_c (dec_new[j]),
            .dec_hi_c (dec_new[j+N_BFLY])
        );
    end

    // Drop the common MSB once every survivor has it; differences are unchanged.
    always_comb begin
        norm_c = 1'b1;
        for (int i = 0; i < int'(N_STATES); i++) begin
            norm_c = norm_c & pm_new[i][PM_W-1];
        end
        pm_upd = pm_new;
        if (norm_c) begin
            for (int i = 0; i < int'(N_STATES); i++) begin
                pm_upd[i][PM_W-1] = 1'b0;
            end
        end
    end

    // Strict compare keeps the lowest index on ties.
    always_comb begin
        min_idx = '0;
        min_val = pm_upd[0];
        for (int i = 1; i < int'(N_STATES); i++) begin
            if (pm_upd[i] < min_val) begin
                min_val = pm_upd[i];
                min_idx = S_W'(i);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pm_q[0] <= '0;
            for (int i = 1; i < int'(N_STATES); i++) begin
                pm_q[i] <= INIT_VAL;
            end
            dec         <= '0;
            dec_valid   <= 1'b0;
            best_state  <= '0;
            best_metric <= '0;
        end else if (start) begin
            pm_q[0] <= '0;
            for (int i = 1; i < int'(N_STATES); i++) begin
                pm_q[i] <= INIT_VAL;
            end
            dec         <= '0;
            dec_valid   <= 1'b0;
            best_state  <= '0;
            best_metric <= '0;
        end else if (sym_valid) begin
            pm_q        <= pm_upd;
            dec         <= dec_new;
            dec_valid   <= 1'b1;
            best_state  <= min_idx;
            best_metric <= min_val;
        end else begin
            dec_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vit_acs.sv
// Scoreboard bench for vit_acs: a plain-arithmetic trellis model predicts every
// output cycle; a monitor compares the DUT one clock after each driven cycle.
module tb_vit_acs;

    localparam int PM_W    = 6;
    localparam int INIT_PM = 16;
    localparam int PM_MAX  = (1 << PM_W) - 1;
    localparam int HALF    = 1 << (PM_W - 1);

    logic       clock;
    logic       reset;
    logic       start;
    logic [1:0] rx_sym;
    logic       sym_valid;
    logic [7:0] dec;
    logic       dec_valid;
    logic [2:0] best_state;
    logic [PM_W-1:0] best_metric;

    vit_acs #(
        .PM_W        (PM_W),
        .INIT_PM     (INIT_PM)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .rx_sym      (rx_sym),
        .sym_valid   (sym_valid),
        .dec         (dec),
        .dec_valid   (dec_valid),
        .best_state  (best_state),
        .best_metric (best_metric)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit valid;
        int dec;
        int bs;
        int bm;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] dec_log[$];
    int checks = 0;
    int errors = 0;

    int m_pm[8];
    int m_dec, m_bs, m_bm;
    int norm_events = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_init();
        m_pm[0] = 0;
        for (int i = 1; i < 8; i++) m_pm[i] = INIT_PM;
        m_dec = 0;
        m_bs  = 0;
        m_bm  = 0;
    endtask

    // Trellis recursion straight from the code definition.
    task automatic model_step(input logic [1:0] rx);
        int newpm[8];
        int cand[2];
        int d;
        bit all_hi;
        d = 0;
        for (int ns = 0; ns < 8; ns++) begin
            int u;
            u = (ns >> 2) & 1;
            for (int b = 0; b < 2; b++) begin
                int p, s2, s1, s0, v1, v0, bm;
                p  = ((ns & 3) << 1) | b;
                s2 = (p >> 2) & 1;
                s1 = (p >> 1) & 1;
                s0 = p & 1;
                v1 = u ^ s1 ^ s0;
                v0 = u ^ s2 ^ s1 ^ s0;
                bm = ((int'(rx[1]) != v1) ? 1 : 0) + ((int'(rx[0]) != v0) ? 1 : 0);
                cand[b] = m_pm[p] + bm;
            end
            if (cand[1] < cand[0]) begin
                d = d | (1 << ns);
                newpm[ns] = cand[1];
            end else begin
                newpm[ns] = cand[0];
            end
            if (newpm[ns] > PM_MAX) newpm[ns] = PM_MAX;
        end
        all_hi = 1'b1;
        for (int i = 0; i < 8; i++) if (newpm[i] < HALF) all_hi = 1'b0;
        if (all_hi) begin
            norm_events++;
            for (int i = 0; i < 8; i++) newpm[i] = newpm[i] - HALF;
        end
        m_bs = 0;
        m_bm = newpm[0];
        for (int i = 1; i < 8; i++) begin
            if (newpm[i] < m_bm) begin
                m_bm = newpm[i];
                m_bs = i;
            end
        end
        for (int i = 0; i < 8; i++) m_pm[i] = newpm[i];
        m_dec = d;
    endtask

    task automatic step(input bit st, input bit v, input logic [1:0] sym);
        exp_t e;
        @(negedge clock);
        start     = st;
        sym_valid = v;
        rx_sym    = sym;
        if (st) model_init();
        else if (v) model_step(sym);
        e.valid = v && !st;
        e.dec   = m_dec;
        e.bs    = m_bs;
        e.bm    = m_bm;
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset     = 1'b1;
        start     = 1'b0;
        sym_valid = 1'b0;
        #1;
        check("rst_dec_valid", int'(dec_valid), 0);
        check("rst_dec", int'(dec), 0);
        check("rst_best_state", int'(best_state), 0);
        check("rst_best_metric", int'(best_metric), 0);
        sb_q.delete();
        model_init();
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // Monitor: one scoreboard entry per driven cycle, sampled after the next edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("dec_valid", int'(dec_valid), int'(e.valid));
                check("dec", int'(dec), e.dec);
                check("best_state", int'(best_state), e.bs);
                check("best_metric", int'(best_metric), e.bm);
                if (e.valid) dec_log.push_back(dec);
            end else if (dec_valid === 1'b1) begin
                checks++;
                errors++;
                $display("FAIL unexpected_dec_valid actual=1 expected=0 at %0t", $time);
            end
        end
    end

    task automatic drain();
        int budget;
        budget = 20;
        while (sb_q.size() > 0 && budget > 0) begin
            @(negedge clock);
            budget--;
        end
        check("drain_timeout", sb_q.size(), 0);
    endtask

    task automatic run_encoder(input bit flip_third);
        int bits[7] = '{1, 0, 1, 1, 0, 0, 0};
        int s;
        s = 0;
        for (int t = 0; t < 7; t++) begin
            int u, v1, v0;
            logic [1:0] sym;
            u  = bits[t];
            v1 = u ^ ((s >> 1) & 1) ^ (s & 1);
            v0 = u ^ ((s >> 2) & 1) ^ ((s >> 1) & 1) ^ (s & 1);
            sym = {v1[0], v0[0]};
            if (flip_third && t == 2) sym[1] = ~sym[1];
            step(1'b0, 1'b1, sym);
            s = (u << 2) | (s >> 1);
        end
        step(1'b0, 1'b0, 2'b00);
    endtask

    initial begin
        int bits[7] = '{1, 0, 1, 1, 0, 0, 0};
        reset     = 1'b1;
        start     = 1'b0;
        sym_valid = 1'b0;
        rx_sym    = 2'b00;
        #1;
        check("init_dec_valid", int'(dec_valid), 0);
        check("init_best_metric", int'(best_metric), 0);
        model_init();
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // Single 11 symbol from the initial metrics.
        step(1'b0, 1'b1, 2'b11);
        step(1'b0, 1'b0, 2'b00);

        // All-zero codeword.
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 2'b00);
        step(1'b0, 1'b0, 2'b00);

        // Error-free encoder stream.
        do_reset();
        run_encoder(1'b0);
        drain();

        // One channel error, then trace back through the DUT decisions.
        do_reset();
        dec_log.delete();
        run_encoder(1'b1);
        drain();
        check("traceback_len", dec_log.size(), 7);
        if (dec_log.size() == 7) begin
            logic [2:0] st;
            logic [7:0] dv;
            st = 3'd0;
            for (int t = 6; t >= 0; t--) begin
                dv = dec_log[t];
                check("traceback_bit", int'(st[2]), bits[t]);
                st = {st[1:0], dv[st]};
            end
        end

        // Randomized traffic with gaps and occasional restarts.
        do_reset();
        for (int i = 0; i < 500; i++) begin
            bit v, st;
            v  = ($urandom_range(0, 9) != 0);
            st = ($urandom_range(0, 99) == 0);
            step(st, v, 2'($urandom));
        end

        // start coinciding with a symbol drops it.
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 2'($urandom));
        step(1'b1, 1'b1, 2'b11);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2'($urandom));

        // start during an idle stretch.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 2'($urandom));
        step(1'b0, 1'b0, 2'b00);
        step(1'b0, 1'b0, 2'b00);
        step(1'b1, 1'b0, 2'b00);
        step(1'b0, 1'b0, 2'b00);
        step(1'b0, 1'b0, 2'b00);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2'($urandom));

        // Reset in the middle of a frame.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 2'($urandom));
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 2'($urandom));
        step(1'b0, 1'b0, 2'b00);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
